// File: rtl/leds_pwm.sv
// Wishbone-mapped PWM LED controller: one duty register per colour channel, shadowed so that
// duty changes take effect only at the PWM period boundary. rgb_leds_o[k] = {r, g, b}.
module leds_pwm #(
  parameter int unsigned N_GREEN  = 4,
  parameter int unsigned N_RGB    = 4,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned PRE_BITS = 16,
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         adr_i,
  input  logic [DW-1:0]         dat_i,
  output logic [DW-1:0]         dat_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  stall_o,
  output logic                  rty_o,
  output logic [N_GREEN-1:0]    green_leds_o,
  output logic [N_RGB-1:0][2:0] rgb_leds_o
);

  localparam int unsigned NCH = N_GREEN + 3 * N_RGB;

  logic [NCH-1:0][PWM_BITS-1:0] pending_q, pending_d;
  logic [NCH-1:0][PWM_BITS-1:0] active_q, active_d;
  logic [PRE_BITS-1:0]          prescale_q, prescale_d;
  logic                         enable_q, enable_d;
  logic [PRE_BITS-1:0]          pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]          pwm_cnt_q, pwm_cnt_d;
  logic [NCH-1:0]               led_q, led_d;
  logic                         ack_q, ack_d;
  logic                         err_q, err_d;
  logic [DW-1:0]                dat_q, dat_d;

  logic req, adr_ok, tick, wrap;

  assign req    = cyc_i & stb_i;
  // Full-width compare also rejects any set upper address bits.
  assign adr_ok = (adr_i <= AW'(NCH));
  assign tick   = enable_q && (pre_cnt_q >= prescale_q);
  assign wrap   = tick && (pwm_cnt_q == {PWM_BITS{1'b1}});

  // Bus decode and register writes
  always_comb begin
    pending_d  = pending_q;
    prescale_d = prescale_q;
    enable_d   = enable_q;
    ack_d      = req & adr_ok;
    err_d      = req & ~adr_ok;
    dat_d      = '0;
    if (req && adr_ok) begin
      if (we_i) begin
        if (adr_i == '0) begin
          prescale_d = dat_i[PRE_BITS:1];
          enable_d   = dat_i[0];
        end
        for (int unsigned i = 0; i < NCH; i++) begin
          if (adr_i == AW'(i + 1)) pending_d[i] = dat_i[PWM_BITS-1:0];
        end
      end else begin
        if (adr_i == '0) dat_d = DW'({prescale_q, enable_q});
        for (int unsigned i = 0; i < NCH; i++) begin
          if (adr_i == AW'(i + 1)) dat_d = DW'(pending_q[i]);
        end
      end
    end
  end

  // Prescaler, PWM counter, shadow transfer and output compare
  always_comb begin
    pre_cnt_d = '0;
    pwm_cnt_d = '0;
    if (enable_q) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    end
    // Taking pending_d lets a write on the wrap tick win over the old pending value.
    active_d = (!enable_q || wrap) ? pending_d : active_q;
    led_d    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      led_d[i] = enable_q && (pwm_cnt_q < active_q[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      active_q   <= '0;
      prescale_q <= '0;
      enable_q   <= 1'b0;
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      led_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      pending_q  <= pending_d;
      active_q   <= active_d;
      prescale_q <= prescale_d;
      enable_q   <= enable_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      led_q      <= led_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
    end
  end

  assign dat_o        = dat_q;
  assign ack_o        = ack_q;
  assign err_o        = err_q;
  assign stall_o      = 1'b0;
  assign rty_o        = 1'b0;
  assign green_leds_o = led_q[N_GREEN-1:0];

  for (genvar k = 0; k < N_RGB; k++) begin : g_rgb
    assign rgb_leds_o[k] = {led_q[N_GREEN+3*k], led_q[N_GREEN+3*k+1], led_q[N_GREEN+3*k+2]};
  end

endmodule

// File: tb/tb_leds_pwm.sv
// Directed bench for leds_pwm: register map table plus PWM, shadowing, mapping and reset cases.
module tb_leds_pwm;

  logic             clk, rst, cyc, stb, we;
  logic [31:0]      adr, dat_w, dat_r;
  logic             ack, err, stall, rty;
  logic [3:0]       green;
  logic [3:0][2:0]  rgb;

  int checks   = 0;
  int failures = 0;

  leds_pwm dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cyc_i       (cyc),
    .stb_i       (stb),
    .we_i        (we),
    .adr_i       (adr),
    .dat_i       (dat_w),
    .dat_o       (dat_r),
    .ack_o       (ack),
    .err_o       (err),
    .stall_o     (stall),
    .rty_o       (rty),
    .green_leds_o(green),
    .rgb_leds_o  (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ack;
    logic        err;
    logic [31:0] rdat;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One single-cycle request; responses sampled on the following negedge.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic r_ack, output logic r_err, output logic [31:0] r_dat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
    @(negedge clk);
    r_ack = ack; r_err = err; r_dat = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic k, e;
    logic [31:0] r;
    bus(1'b1, a, d, k, e, r);
    chk("wr_ack", {31'd0, k}, 32'd1);
  endtask

  task automatic window(input int n, output int c_g0, output int c_b1, output int c_rest);
    c_g0 = 0; c_b1 = 0; c_rest = 0;
    repeat (n) begin
      @(negedge clk);
      c_g0   += int'(green[0]);
      c_b1   += int'(rgb[1][0]);
      c_rest += $countones(green[3:1]) + $countones(rgb) - int'(rgb[1][0]);
    end
  endtask

  initial begin
    logic        k, e;
    logic [31:0] r;
    int          g0, b1, rest, t;
    logic        prev;

    tbl[0]  = '{1'b1, 32'd0,     32'h3,   1'b1, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'd3,     32'h80,  1'b1, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'd0,     32'h0,   1'b1, 1'b0, 32'h3};
    tbl[3]  = '{1'b0, 32'd3,     32'h0,   1'b1, 1'b0, 32'h80};
    tbl[4]  = '{1'b1, 32'd17,    32'hFF,  1'b0, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, 32'd17,    32'h0,   1'b0, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 32'h101,   32'h55,  1'b0, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 32'd4,     32'h1FF, 1'b1, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 32'd4,     32'h0,   1'b1, 1'b0, 32'hFF};
    tbl[9]  = '{1'b0, 32'd0,     32'h0,   1'b1, 1'b0, 32'h3};
    tbl[10] = '{1'b0, 32'd3,     32'h0,   1'b1, 1'b0, 32'h80};
    tbl[11] = '{1'b1, 32'd0,     32'h0,   1'b1, 1'b0, 32'h0};

    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dat", dat_r, 32'd0);
    chk("rst_leds", {16'd0, rgb, green}, 32'd0);
    chk("stall_rty", {30'd0, stall, rty}, 32'd0);
    rst = 1'b0;

    // Register map, readback and error responses
    for (int i = 0; i < 12; i++) begin
      bus(tbl[i].we, tbl[i].adr, tbl[i].dat, k, e, r);
      chk($sformatf("tbl%0d_ack", i), {31'd0, k}, {31'd0, tbl[i].ack});
      chk($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].err});
      if (!tbl[i].we) chk($sformatf("tbl%0d_dat", i), r, tbl[i].rdat);
      @(negedge clk);
      chk($sformatf("tbl%0d_idle", i), {30'd0, ack, err}, 32'd0);
    end

    // PWM duty 64 / 0 / 255 with prescale 0
    wr(32'd1, 32'd64);
    wr(32'd0, 32'd1);
    repeat (10) @(negedge clk);
    window(256, g0, b1, rest);
    chk("duty64", g0, 32'd64);
    wr(32'd1, 32'd0);
    repeat (300) @(negedge clk);
    window(256, g0, b1, rest);
    chk("duty0", g0, 32'd0);
    wr(32'd1, 32'd255);
    repeat (300) @(negedge clk);
    window(256, g0, b1, rest);
    chk("duty255", g0, 32'd255);

    // Shadowing: change 64 -> 192 mid-period
    wr(32'd1, 32'd64);
    repeat (300) @(negedge clk);
    prev = green[0];
    t = 0;
    while (!(green[0] && !prev) && t < 600) begin
      prev = green[0];
      @(negedge clk);
      t++;
    end
    chk("sync_timeout", {31'd0, t >= 600}, 32'd0);
    g0 = 1;
    for (int j = 1; j < 256; j++) begin
      if (j == 100) begin
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd1; dat_w = 32'd192;
      end else if (j == 101) begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
      end
      @(negedge clk);
      g0 += int'(green[0]);
    end
    chk("shadow_cur", g0, 32'd64);
    window(256, g0, b1, rest);
    chk("shadow_next", g0, 32'd192);

    // Disable clears outputs on the following cycle
    wr(32'd0, 32'd0);
    @(negedge clk);
    chk("disable_leds", {16'd0, rgb, green}, 32'd0);

    // Mapping and prescale: only rgb_leds[1].b, 4 cycles per PWM count
    wr(32'd1, 32'd0);
    wr(32'd3, 32'd0);
    wr(32'd4, 32'd0);
    wr(32'd10, 32'd255);
    wr(32'd0, 32'd7);
    repeat (16) @(negedge clk);
    window(1024, g0, b1, rest);
    chk("map_b1", b1, 32'd1020);
    chk("map_rest", rest, 32'd0);

    // Reset asserted while a write is being answered
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd10; dat_w = 32'd0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ack", {30'd0, ack, err}, 32'd0);
    chk("midrst_leds", {16'd0, rgb, green}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_resp", {30'd0, ack, err}, 32'd0);
    bus(1'b0, 32'd10, 32'd0, k, e, r);
    chk("postrst_duty", r, 32'd0);
    bus(1'b0, 32'd0, 32'd0, k, e, r);
    chk("postrst_ctrl", r, 32'd0);
    chk("postrst_ack", {31'd0, k}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
